butterfly_load_sequencer: RTL and testbench
===========================================

# butterfly_load_sequencer

Sequential, parametrised operand loader for the radix-2 butterfly datapath. It sits between the sample buffer and the twiddle ROM on the input side and the butterfly operand buffer on the output side. On each `start` it emits one frame on a single word stream: `NUM_SAMPLES` sample words, then `NUM_TWIDDLES` twiddle pairs (real word, then imag word). All transfers use valid/ready handshakes. A unity-twiddle mode substitutes constant 1+j0 for first-stage butterflies.

## Interface
Parameters:
- `DATA_W`, 16, word width of samples, twiddles and output
- `NUM_SAMPLES`, 4, sample words per frame (≥1)
- `NUM_TWIDDLES`, 1, twiddle pairs per frame (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  frame request; honoured only in IDLE
- `unity_twiddle`  in  1  mode select; captured on the accepted `start`
- `sample_in`  in  DATA_W  sample word
- `sample_valid`  in  1  `sample_in` valid
- `sample_ready`  out  1  sample consumed this cycle
- `twiddle_real`, `twiddle_imag`  in  DATA_W each  current twiddle pair
- `tw_valid`  in  1  twiddle pair valid
- `tw_ready`  out  1  pair consumed this cycle (the imag-word cycle)
- `tw_index`  out  TW_IDX_W  index of the twiddle pair being fetched
- `output_value`  out  DATA_W  registered output word
- `out_valid`  out  1  `output_value` valid
- `out_ready`  in  1  downstream accepts
- `out_last`  out  1  qualifies the final word of the frame
- `load_count`  out  CNT_W  words handed out in the current frame
- `busy`  out  1  frame in progress

## Operation
- FSM states: IDLE, SAMPLE, TW_RE, TW_IM, DRAIN.
- IDLE → SAMPLE when `start` is high. This clears `load_count`, `sample_idx` and `tw_index`, and latches `unity_twiddle`. `start` is ignored outside IDLE.
- A single output register holds one word. `slot_free = !out_valid || out_ready`. An input word is accepted only when `slot_free` is true.
- SAMPLE:
  - Accept when `sample_valid && slot_free`. `sample_ready` is high in exactly that cycle.
  - After accept number `NUM_SAMPLES`, go to TW_RE.
- TW_RE:
  - Normal mode: accept when `tw_valid && slot_free`. Load `twiddle_real`. `tw_ready` stays low.
  - Unity mode: load 0x7FFF (Q1.15 +1, i.e. `{1'b0,{DATA_W-1{1'b1}}}`) when `slot_free`. `tw_valid` is ignored.
- TW_IM:
  - Normal mode: accept when `tw_valid && slot_free`. Load `twiddle_imag`, pulse `tw_ready`, increment `tw_index`.
  - Unity mode: load zero and increment `tw_index`. `tw_ready` is never asserted.
  - If more pairs remain, go to TW_RE. Otherwise go to DRAIN.
- If `tw_valid` drops between the real and imag accepts, the FSM stalls in TW_IM until it returns.
- DRAIN: when the last word handshakes out (`out_valid && out_ready && out_last`), go to IDLE. If `start` is high in that same cycle, it is not honoured; it must be re-asserted in IDLE.
- `load_count` increments on every output handshake and saturates at FRAME_WORDS. It is cleared only by the next accepted `start` or by reset.
- `busy` is high in every state except IDLE.
- `out_last` is registered alongside the word. It is high for the final TW_IM word.

## Timing
- Reset values: `output_value` 0, `out_valid` 0, `out_last` 0, `sample_ready` 0, `tw_ready` 0, `tw_index` 0, `load_count` 0, `busy` 0. FSM resets to IDLE.
- `n_rst` asserted mid-frame aborts the frame immediately. No partial frame resumes after reset.
- The `start` edge moves the FSM to SAMPLE. The first sample can be accepted in the following cycle.
- Latency: an accepted input word appears on `output_value` one cycle later with `out_valid` high.
- Throughput is one word per cycle while `out_ready` is held high. Minimum frame is FRAME_WORDS + 1 cycles from start to IDLE.
- Backpressure: while `out_valid && !out_ready`, the output holds `output_value`, `out_last` and `out_valid` stable. No input ready is asserted during this time.
- `sample_ready` and `tw_ready` are combinational from state, valids and `out_ready`. No input valid ever depends on a ready.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum `load_state_t`
  - the Q1.15 constants `TW_ONE` and `TW_ZERO`
  - localparams FRAME_WORDS = NUM_SAMPLES + 2·NUM_TWIDDLES, CNT_W = $clog2(FRAME_WORDS+1) and TW_IDX_W = max(1, $clog2(NUM_TWIDDLES)).
- One sub-module, `load_output_reg`: a one-entry valid/ready register carrying data plus `last`. The FSM and counters stay in the top module.

## Test plan
- Defaults, all valids and `out_ready` held high, `start` pulse → outputs S0..S3, then twiddle_real 0x5A82, then twiddle_imag 0xA57E on consecutive cycles. `out_last` is high only on 0xA57E. `tw_ready` pulses once. `load_count` ends at 6. IDLE is reached 7 cycles after `start`.
- Unity mode, `tw_valid` held low → words 5 and 6 are 0x7FFF and 0x0000. `tw_ready` never rises. The frame completes.
- `out_ready` low for 3 cycles on word 2 → `output_value` and `out_valid` are stable for those 3 cycles. `sample_ready` is low throughout. No word is lost or duplicated.
- `tw_valid` dropped for 2 cycles after the real-word accept → the FSM holds in TW_IM and the imag word follows after `tw_valid` returns. NUM_TWIDDLES=2 → `tw_index` steps 0→1 and `tw_ready` pulses twice.
- `start` asserted while busy → ignored. `n_rst` pulsed after word 3 → all outputs return to their reset values. A fresh `start` then yields a full 6-word frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the butterfly operand loader.
// Holds the loader state enum, the Q1.15 unity-twiddle constants and the
// helper functions that derive frame size and counter widths from parameters.
package fft_pkg;

  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_NUM_SAMPLES  = 4;
  localparam int unsigned DEF_NUM_TWIDDLES = 1;

  // Q1.15 +1 and 0, used as the 1+j0 twiddle in unity mode.
  localparam logic [15:0] TW_ONE  = 16'h7FFF;
  localparam logic [15:0] TW_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TW_RE,
    ST_TW_IM,
    ST_DRAIN
  } load_state_t;

  // Words per frame: all samples, then a real/imag word per twiddle pair.
  function automatic int unsigned frame_words(input int unsigned ns, input int unsigned nt);
    return ns + 2 * nt;
  endfunction

  // Width able to hold 0..FRAME_WORDS.
  function automatic int unsigned cnt_width(input int unsigned ns, input int unsigned nt);
    return $clog2(frame_words(ns, nt) + 1);
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/butterfly_load_sequencer_if.sv
// Bus bundle of the butterfly operand loader.
// slave  : the loader (receives start, sample and twiddle streams, drives output stream)
// master : the environment (sample buffer, twiddle ROM, operand buffer, control)
interface butterfly_load_sequencer_if
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int unsigned NUM_TWIDDLES = DEF_NUM_TWIDDLES
);

  localparam int unsigned CNT_W    = cnt_width(NUM_SAMPLES, NUM_TWIDDLES);
  localparam int unsigned TW_IDX_W = idx_width(NUM_TWIDDLES);

  logic                start;
  logic                unity_twiddle;
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic [DATA_W-1:0]   twiddle_real;
  logic [DATA_W-1:0]   twiddle_imag;
  logic                tw_valid;
  logic                tw_ready;
  logic [TW_IDX_W-1:0] tw_index;
  logic [DATA_W-1:0]   output_value;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [CNT_W-1:0]    load_count;
  logic                busy;

  modport slave (
    input  start, unity_twiddle, sample_in, sample_valid,
           twiddle_real, twiddle_imag, tw_valid, out_ready,
    output sample_ready, tw_ready, tw_index, output_value,
           out_valid, out_last, load_count, busy
  );

  modport master (
    output start, unity_twiddle, sample_in, sample_valid,
           twiddle_real, twiddle_imag, tw_valid, out_ready,
    input  sample_ready, tw_ready, tw_index, output_value,
           out_valid, out_last, load_count, busy
  );

endinterface

// File: rtl/butterfly_load_sequencer_output_reg.sv
// load_output_reg: one-entry valid/ready holding register carrying a word and
// its last flag.
// Ports: load_c (write a new word this cycle), in_data/in_last (word to write),
// out_ready (downstream accept), slot_free_c (a write may happen this cycle),
// out_valid/out_data/out_last (registered output).
module load_output_reg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_c,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              slot_free_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;

  // Slot is free when empty or when the held word leaves this cycle.
  assign slot_free_c = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_c) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/butterfly_load_sequencer.sv
// butterfly_load_sequencer: on each start, streams NUM_SAMPLES sample words and
// then NUM_TWIDDLES twiddle pairs (real, imag) into the butterfly operand buffer
// through a single registered output slot. Unity mode substitutes 1+j0 twiddles.
// Ports: clk, n_rst (async active-low), bus (slave side of the loader bundle:
// start/unity_twiddle control, sample and twiddle input streams, output stream,
// tw_index, load_count, busy).
module butterfly_load_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int unsigned NUM_TWIDDLES = DEF_NUM_TWIDDLES
) (
  input  logic                      clk,
  input  logic                      n_rst,
  butterfly_load_sequencer_if.slave bus
);

  localparam int unsigned FRAME_WORDS = frame_words(NUM_SAMPLES, NUM_TWIDDLES);
  localparam int unsigned CNT_W       = cnt_width(NUM_SAMPLES, NUM_TWIDDLES);
  localparam int unsigned TW_IDX_W    = idx_width(NUM_TWIDDLES);
  localparam int unsigned SIDX_W      = idx_width(NUM_SAMPLES);

  localparam logic [DATA_W-1:0] TW_ONE_W  = (DATA_W == 16) ? DATA_W'(TW_ONE)
                                                           : {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] TW_ZERO_W = DATA_W'(TW_ZERO);

  load_state_t         state_q,      state_d;
  logic [SIDX_W-1:0]   sample_idx_q, sample_idx_d;
  logic [TW_IDX_W-1:0] tw_index_q,   tw_index_d;
  logic [CNT_W-1:0]    load_count_q, load_count_d;
  logic                unity_q,      unity_d;
  logic                busy_q,       busy_d;

  logic              slot_free_c;
  logic              out_fire_c;
  logic              load_c;
  logic [DATA_W-1:0] load_data_c;
  logic              load_last_c;
  logic              sample_ready_c;
  logic              tw_ready_c;

  assign out_fire_c = bus.out_valid && bus.out_ready;

  // Next-state, counters and the word offered to the output slot.
  always_comb begin
    state_d        = state_q;
    sample_idx_d   = sample_idx_q;
    tw_index_d     = tw_index_q;
    load_count_d   = load_count_q;
    unity_d        = unity_q;
    load_c         = 1'b0;
    load_data_c    = '0;
    load_last_c    = 1'b0;
    sample_ready_c = 1'b0;
    tw_ready_c     = 1'b0;

    if (out_fire_c && (load_count_q != CNT_W'(FRAME_WORDS))) begin
      load_count_d = load_count_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_SAMPLE;
          load_count_d = '0;
          sample_idx_d = '0;
          tw_index_d   = '0;
          unity_d      = bus.unity_twiddle;
        end
      end
      ST_SAMPLE: begin
        if (bus.sample_valid && slot_free_c) begin
          load_c         = 1'b1;
          load_data_c    = bus.sample_in;
          sample_ready_c = 1'b1;
          sample_idx_d   = sample_idx_q + 1'b1;
          if (sample_idx_q == SIDX_W'(NUM_SAMPLES - 1)) begin
            state_d = ST_TW_RE;
          end
        end
      end
      ST_TW_RE: begin
        // The pair is only acknowledged on the imag word, so no ready here.
        if ((unity_q || bus.tw_valid) && slot_free_c) begin
          load_c      = 1'b1;
          load_data_c = unity_q ? TW_ONE_W : bus.twiddle_real;
          state_d     = ST_TW_IM;
        end
      end
      ST_TW_IM: begin
        if ((unity_q || bus.tw_valid) && slot_free_c) begin
          load_c      = 1'b1;
          load_data_c = unity_q ? TW_ZERO_W : bus.twiddle_imag;
          tw_ready_c  = !unity_q;
          tw_index_d  = tw_index_q + 1'b1;
          if (tw_index_q == TW_IDX_W'(NUM_TWIDDLES - 1)) begin
            load_last_c = 1'b1;
            state_d     = ST_DRAIN;
          end else begin
            state_d = ST_TW_RE;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire_c && bus.out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      sample_idx_q <= '0;
      tw_index_q   <= '0;
      load_count_q <= '0;
      unity_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_idx_q <= sample_idx_d;
      tw_index_q   <= tw_index_d;
      load_count_q <= load_count_d;
      unity_q      <= unity_d;
      busy_q       <= busy_d;
    end
  end

  load_output_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_c      (load_c),
    .in_data     (load_data_c),
    .in_last     (load_last_c),
    .out_ready   (bus.out_ready),
    .slot_free_c (slot_free_c),
    .out_valid   (bus.out_valid),
    .out_data    (bus.output_value),
    .out_last    (bus.out_last)
  );

  assign bus.sample_ready = sample_ready_c;
  assign bus.tw_ready     = tw_ready_c;
  assign bus.tw_index     = tw_index_q;
  assign bus.load_count   = load_count_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_butterfly_load_sequencer.sv
// Bench for butterfly_load_sequencer: two instances (one and two twiddle pairs)
// share the control inputs; each has its own sample/twiddle source and a
// frame-level reference model checked every cycle, plus literal frame checks.
module tb_butterfly_load_sequencer;

  localparam int NS = 4;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic start, unity, sv, tv, ordy;

  logic [15:0] samples [8];
  logic [15:0] tw_re [2];
  logic [15:0] tw_im [2];
  logic [2:0]  sp [NI];
  logic        adv [NI];
  logic        sp_rst [NI];
  logic [16:0] exp_n [NI][8];

  butterfly_load_sequencer_if                      ia ();
  butterfly_load_sequencer_if #(.NUM_TWIDDLES(2)) ib ();

  butterfly_load_sequencer dut_a (.clk(clk), .n_rst(n_rst), .bus(ia));
  butterfly_load_sequencer #(.NUM_TWIDDLES(2)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ib));

  assign ia.start = start;          assign ib.start = start;
  assign ia.unity_twiddle = unity;  assign ib.unity_twiddle = unity;
  assign ia.sample_valid = sv;      assign ib.sample_valid = sv;
  assign ia.tw_valid = tv;          assign ib.tw_valid = tv;
  assign ia.out_ready = ordy;       assign ib.out_ready = ordy;
  assign ia.sample_in = samples[sp[0]];
  assign ib.sample_in = samples[sp[1]];
  assign ia.twiddle_real = tw_re[ia.tw_index];
  assign ia.twiddle_imag = tw_im[ia.tw_index];
  assign ib.twiddle_real = tw_re[ib.tw_index];
  assign ib.twiddle_imag = tw_im[ib.tw_index];

  logic [15:0] ov_w [NI];
  logic        ovl [NI], olast [NI], srdy [NI], trdy [NI], bsy [NI];
  logic [3:0]  lcnt [NI];
  logic        tidx [NI];
  logic [15:0] sin [NI], tim [NI];

  assign ov_w[0] = ia.output_value;  assign ov_w[1] = ib.output_value;
  assign ovl[0] = ia.out_valid;      assign ovl[1] = ib.out_valid;
  assign olast[0] = ia.out_last;     assign olast[1] = ib.out_last;
  assign srdy[0] = ia.sample_ready;  assign srdy[1] = ib.sample_ready;
  assign trdy[0] = ia.tw_ready;      assign trdy[1] = ib.tw_ready;
  assign bsy[0] = ia.busy;           assign bsy[1] = ib.busy;
  assign lcnt[0] = 4'(ia.load_count); assign lcnt[1] = 4'(ib.load_count);
  assign tidx[0] = ia.tw_index;      assign tidx[1] = ib.tw_index;
  assign sin[0] = ia.sample_in;      assign sin[1] = ib.sample_in;
  assign tim[0] = ia.twiddle_imag;   assign tim[1] = ib.twiddle_imag;

  int vectors = 0;
  int errors  = 0;

  // Reference model state and observation logs.
  logic        m_busy [NI], m_unity [NI];
  int          m_pos [NI], m_cnt [NI], ftr [NI], trcnt [NI], bcnt [NI];
  logic        hold [NI], hold_l [NI], acc [NI];
  logic [15:0] hold_w [NI], acc_w [NI];
  logic [16:0] wlog [NI][16];
  int          wn [NI];
  logic        tilog [NI][8];
  int          tn [NI];
  logic        wb;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic int fw(input int i);
    return NS + 2 * (i + 1);
  endfunction

  // Expected k-th word of the current frame of instance i.
  function automatic logic [15:0] exp_word(input int i, input int k);
    int p;
    if (k < NS) return samples[k];
    p = (k - NS) / 2;
    if (((k - NS) % 2) == 0) return m_unity[i] ? 16'h7FFF : tw_re[p];
    return m_unity[i] ? 16'h0000 : tw_im[p];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!n_rst) begin
        chk("rst_out_valid", i, 32'(ovl[i]), 32'd0);
        chk("rst_output_value", i, 32'(ov_w[i]), 32'd0);
        chk("rst_out_last", i, 32'(olast[i]), 32'd0);
        chk("rst_sample_ready", i, 32'(srdy[i]), 32'd0);
        chk("rst_tw_ready", i, 32'(trdy[i]), 32'd0);
        chk("rst_tw_index", i, 32'(tidx[i]), 32'd0);
        chk("rst_load_count", i, 32'(lcnt[i]), 32'd0);
        chk("rst_busy", i, 32'(bsy[i]), 32'd0);
        m_busy[i] = 1'b0; m_pos[i] = 0; m_cnt[i] = 0;
        hold[i] = 1'b0; acc[i] = 1'b0; sp_rst[i] = 1'b1;
      end else begin
        wb = m_busy[i];
        if (hold[i]) begin
          chk("stall_valid", i, 32'(ovl[i]), 32'd1);
          chk("stall_word", i, 32'(ov_w[i]), 32'(hold_w[i]));
          chk("stall_last", i, 32'(olast[i]), 32'(hold_l[i]));
        end
        if (acc[i]) begin
          chk("latency_valid", i, 32'(ovl[i]), 32'd1);
          chk("latency_word", i, 32'(ov_w[i]), 32'(acc_w[i]));
        end
        chk("busy", i, 32'(bsy[i]), 32'(wb));
        chk("load_count", i, 32'(lcnt[i]), 32'(m_cnt[i]));
        if (!wb) chk("idle_out_valid", i, 32'(ovl[i]), 32'd0);
        if (srdy[i]) chk("sample_ready_cond", i, 32'(sv && (!ovl[i] || ordy)), 32'd1);
        if (trdy[i]) begin
          chk("tw_ready_cond", i, 32'(tv && (!ovl[i] || ordy) && !m_unity[i]), 32'd1);
          ftr[i]++; trcnt[i]++;
          if (tn[i] < 8) begin tilog[i][tn[i]] = tidx[i]; tn[i]++; end
        end
        hold[i]   = ovl[i] && !ordy;
        hold_w[i] = ov_w[i];
        hold_l[i] = olast[i];
        acc[i]    = (srdy[i] && sv) || (trdy[i] && tv);
        acc_w[i]  = srdy[i] ? sin[i] : tim[i];
        if (srdy[i] && sv) adv[i] = 1'b1;
        if (ovl[i] && ordy) begin
          chk("word_expected", i, 32'(wb && (m_pos[i] < fw(i))), 32'd1);
          if (wb && (m_pos[i] < fw(i))) begin
            chk("word", i, 32'(ov_w[i]), 32'(exp_word(i, m_pos[i])));
            chk("out_last", i, 32'(olast[i]), 32'(m_pos[i] == fw(i) - 1));
            if (wn[i] < 16) begin wlog[i][wn[i]] = {olast[i], ov_w[i]}; wn[i]++; end
            m_cnt[i]++;
            if (m_pos[i] == fw(i) - 1) begin
              chk("frame_tw_ready_count", i, 32'(ftr[i]), m_unity[i] ? 32'd0 : 32'(i + 1));
              m_busy[i] = 1'b0;
            end
            m_pos[i]++;
          end
        end
        if (start && !wb) begin
          m_busy[i] = 1'b1; m_unity[i] = unity; m_pos[i] = 0; m_cnt[i] = 0;
          ftr[i] = 0; sp_rst[i] = 1'b1;
        end
        if (bsy[i]) bcnt[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (sp_rst[i]) sp[i] = '0;
      else if (adv[i]) sp[i] = sp[i] + 3'd1;
      sp_rst[i] = 1'b0;
      adv[i]    = 1'b0;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      wn[i] = 0; tn[i] = 0; trcnt[i] = 0; bcnt[i] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 60 && (m_busy[0] || m_busy[1]); c++) tick();
    chk("wait_idle", 0, 32'(m_busy[0] || m_busy[1]), 32'd0);
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 40 && wn[0] < n; c++) tick();
    chk("wait_words", 0, 32'(wn[0] >= n), 32'd1);
  endtask

  task automatic check_frame(input int i, input string nm);
    chk({nm, "_len"}, i, 32'(wn[i]), 32'(fw(i)));
    for (int k = 0; k < fw(i); k++) chk(nm, i, 32'(wlog[i][k]), 32'(exp_n[i][k]));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) samples[k] = 16'(16'h1111 * (k + 1));
    tw_re[0] = 16'h5A82; tw_im[0] = 16'hA57E;
    tw_re[1] = 16'h7641; tw_im[1] = 16'hCF05;
    exp_n[0] = '{17'h01111, 17'h02222, 17'h03333, 17'h04444, 17'h05A82, 17'h1A57E, 17'h0, 17'h0};
    exp_n[1] = '{17'h01111, 17'h02222, 17'h03333, 17'h04444, 17'h05A82, 17'h0A57E, 17'h07641, 17'h1CF05};
    for (int i = 0; i < NI; i++) begin
      sp[i] = '0; adv[i] = 1'b0; sp_rst[i] = 1'b0;
      m_busy[i] = 1'b0; m_unity[i] = 1'b0; m_pos[i] = 0; m_cnt[i] = 0; ftr[i] = 0;
      hold[i] = 1'b0; acc[i] = 1'b0;
    end
    clear_logs();
    n_rst = 1'b0; start = 1'b0; unity = 1'b0; sv = 1'b1; tv = 1'b1; ordy = 1'b1;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();

    // Full-throughput frame.
    clear_logs();
    pulse_start();
    wait_idle();
    check_frame(0, "s1_frame");
    check_frame(1, "s1_frame");
    chk("s1_load_count", 0, 32'(lcnt[0]), 32'd6);
    chk("s1_load_count", 1, 32'(lcnt[1]), 32'd8);
    chk("s1_busy_cycles", 0, 32'(bcnt[0]), 32'd7);
    chk("s1_busy_cycles", 1, 32'(bcnt[1]), 32'd9);
    chk("s1_tw_ready_pulses", 0, 32'(trcnt[0]), 32'd1);
    chk("s1_tw_ready_pulses", 1, 32'(trcnt[1]), 32'd2);
    chk("s1_tw_index_seq_len", 1, 32'(tn[1]), 32'd2);
    chk("s1_tw_index_0", 1, 32'(tilog[1][0]), 32'd0);
    chk("s1_tw_index_1", 1, 32'(tilog[1][1]), 32'd1);
    tick();

    // Unity mode with tw_valid held low.
    clear_logs();
    unity = 1'b1; tv = 1'b0;
    pulse_start();
    unity = 1'b0;
    wait_idle();
    chk("s2_len", 0, 32'(wn[0]), 32'd6);
    chk("s2_word5", 0, 32'(wlog[0][4]), 32'h07FFF);
    chk("s2_word6", 0, 32'(wlog[0][5]), 32'h10000);
    chk("s2_word7", 1, 32'(wlog[1][6]), 32'h07FFF);
    chk("s2_word8", 1, 32'(wlog[1][7]), 32'h10000);
    chk("s2_tw_ready_pulses", 0, 32'(trcnt[0]), 32'd0);
    chk("s2_tw_ready_pulses", 1, 32'(trcnt[1]), 32'd0);
    tv = 1'b1;
    tick();

    // Backpressure for three cycles while word 2 is held.
    clear_logs();
    pulse_start();
    wait_words(2);
    ordy = 1'b0;
    repeat (3) begin
      tick();
      chk("s3_hold_word", 0, 32'(ov_w[0]), 32'h3333);
      chk("s3_hold_valid", 0, 32'(ovl[0]), 32'd1);
      chk("s3_sample_ready", 0, 32'(srdy[0]), 32'd0);
    end
    ordy = 1'b1;
    wait_idle();
    check_frame(0, "s3_frame");
    check_frame(1, "s3_frame");
    tick();

    // tw_valid drops for two cycles right after the real-word accept.
    clear_logs();
    pulse_start();
    wait_words(4);
    tv = 1'b0;
    repeat (2) tick();
    tv = 1'b1;
    wait_idle();
    check_frame(0, "s4_frame");
    check_frame(1, "s4_frame");
    chk("s4_busy_cycles", 0, 32'(bcnt[0]), 32'd9);
    chk("s4_busy_cycles", 1, 32'(bcnt[1]), 32'd11);
    tick();

    // start while busy is ignored.
    clear_logs();
    pulse_start();
    repeat (2) tick();
    pulse_start();
    wait_idle();
    check_frame(0, "s5_frame");
    repeat (3) tick();
    chk("s5_stays_idle", 0, 32'(bsy[0]), 32'd0);
    chk("s5_stays_idle", 1, 32'(bsy[1]), 32'd0);

    // Reset after word 3 aborts the frame; a fresh start gives a full frame.
    clear_logs();
    pulse_start();
    wait_words(3);
    n_rst = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (3) tick();
    chk("s6_no_resume", 0, 32'(bsy[0]), 32'd0);
    chk("s6_no_resume", 1, 32'(bsy[1]), 32'd0);
    chk("s6_count_cleared", 0, 32'(lcnt[0]), 32'd0);
    clear_logs();
    pulse_start();
    wait_idle();
    check_frame(0, "s6_frame");
    check_frame(1, "s6_frame");
    chk("s6_load_count", 0, 32'(lcnt[0]), 32'd6);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
